// File: rtl/mc_control_unit.sv
// Multicycle control unit: main FSM, ALU decoder, flag-write and PC-select logic.
// Build option: define CMP_SKIP_WB_EN to decode CMP/TST and skip their register writeback.
module mc_control_unit #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 IsMul,
  output logic [1:0]           FlagW,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Undef,
  output logic                 Busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_MULEX
  } state_t;

  typedef struct packed {
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       busy;
  } ctrl_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            skip_wb;
  logic            mul_last;
  logic [2:0]      alu3;

  // Control word is precomputed for the state being entered, so outputs come straight from flops.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.ir_write = 1'b1; c.next_pc = 1'b1; c.alu_src_a = 2'b01;
                      c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_MEMADR: c.alu_src_b = 2'b01;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB:  begin c.result_src = 2'b01; c.reg_w = 1'b1; end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      S_EXECR:  c.alu_op = 1'b1;
      S_EXECI:  begin c.alu_src_b = 2'b01; c.alu_op = 1'b1; end
      S_ALUWB:  c.reg_w = 1'b1;
      S_BRANCH: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10;
                      c.branch = 1'b1; end
      S_MULEX:  begin c.alu_op = 1'b1; c.busy = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

`ifdef CMP_SKIP_WB_EN
  assign skip_wb = (Funct[4:1] == 4'b1010) || (Funct[4:1] == 4'b1000);
`else
  assign skip_wb = 1'b0;
`endif

  assign mul_last = (state_q == S_MULEX) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : (IsMul ? S_MULEX : S_EXECR);
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = skip_wb ? S_FETCH : S_ALUWB;
      S_MULEX: begin
        if (mul_last) begin
          cnt_d   = '0;
          state_d = S_ALUWB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    alu3 = 3'd0;
    if (ctrl_q.alu_op) begin
      if (state_q == S_MULEX && IsMul) begin
        alu3 = 3'd5;
      end else begin
        case (Funct[4:1])
          4'b0100: alu3 = 3'd0;
          4'b0010: alu3 = 3'd1;
          4'b0000: alu3 = 3'd2;
          4'b1100: alu3 = 3'd3;
          4'b0001: alu3 = 3'd4;
`ifdef CMP_SKIP_WB_EN
          4'b1010: alu3 = 3'd1;
          4'b1000: alu3 = 3'd2;
`endif
          default: alu3 = 3'd0;
        endcase
      end
    end
  end

  always_comb begin
    FlagW = 2'b00;
    if (ctrl_q.alu_op && (state_q != S_MULEX || mul_last))
      FlagW = {Funct[0], Funct[0] & (alu3[2:1] == 2'b00)};
  end

  assign ALUControl = ALUCTRL_W'(alu3);
  assign Undef      = (state_q == S_DECODE) && (Op == 2'b11);
  assign PCS        = ctrl_q.branch | (ctrl_q.reg_w & (Rd == 4'hF));
  assign NextPC     = ctrl_q.next_pc;
  assign RegW       = ctrl_q.reg_w;
  assign MemW       = ctrl_q.mem_w;
  assign IRWrite    = ctrl_q.ir_write;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign Busy       = ctrl_q.busy;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction-class cycle sequences checked against a table model.
module tb_mc_control_unit;
  localparam int MUL_N = 4;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3, T_MEMWB = 4,
                 T_MEMWR = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BRANCH = 9,
                 T_MULEX = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic       IsMul = 1'b0;
  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, Undef, Busy;
  logic [2:0] ALUControl;
  logic [22:0] got;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control_unit #(.ALUCTRL_W(3), .MUL_CYCLES(MUL_N)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Undef(Undef), .Busy(Busy)
  );

  always #5 clk = ~clk;

  assign got = {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Undef, Busy};

  function automatic int alu_code(input logic [3:0] c);
    case (c)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b0001: return 4;
`ifdef CMP_SKIP_WB_EN
      4'b1010: return 1;
      4'b1000: return 2;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic bit is_skip(input logic [5:0] f);
`ifdef CMP_SKIP_WB_EN
    return (f[4:1] == 4'b1010) || (f[4:1] == 4'b1000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [22:0] exp_vec(input int st, input logic [1:0] op,
      input logic [5:0] f, input logic [3:0] rd, input logic ism, input bit mul_last);
    logic [1:0] fw, rs, asa, asb;
    logic pcs, npc, rw, mw, irw, adr, und, busy, br, aluop;
    logic [2:0] ac;
    fw = 0; rs = 0; asa = 0; asb = 0; npc = 0; rw = 0; mw = 0; irw = 0;
    adr = 0; und = 0; busy = 0; br = 0; aluop = 0;
    case (st)
      T_FETCH:  begin irw = 1; npc = 1; asa = 2'b01; asb = 2'b10; rs = 2'b10; end
      T_DECODE: begin asa = 2'b01; asb = 2'b10; rs = 2'b10; und = (op == 2'b11); end
      T_MEMADR: asb = 2'b01;
      T_MEMRD:  adr = 1;
      T_MEMWB:  begin rs = 2'b01; rw = 1; end
      T_MEMWR:  begin adr = 1; mw = 1; end
      T_EXECR:  aluop = 1;
      T_EXECI:  begin asb = 2'b01; aluop = 1; end
      T_ALUWB:  rw = 1;
      T_BRANCH: begin asa = 2'b10; asb = 2'b01; rs = 2'b10; br = 1; end
      T_MULEX:  begin aluop = 1; busy = 1; end
      default:  ;
    endcase
    if (!aluop) ac = 3'd0;
    else if (st == T_MULEX && ism) ac = 3'd5;
    else ac = 3'(alu_code(f[4:1]));
    if (aluop && (st != T_MULEX || mul_last)) fw = {f[0], f[0] & (ac <= 3'd1)};
    pcs = br | (rw & (rd == 4'hF));
    return {fw, pcs, npc, rw, mw, irw, adr, rs, asa, asb, op,
            op == 2'b01, op == 2'b10, ac, und, busy};
  endfunction

  task automatic build_seq(input logic [1:0] op, input logic [5:0] f, input logic ism,
                           output int seq[$]);
    seq = {};
    seq.push_back(T_FETCH);
    seq.push_back(T_DECODE);
    case (op)
      2'b01: begin
        seq.push_back(T_MEMADR);
        if (f[0]) begin seq.push_back(T_MEMRD); seq.push_back(T_MEMWB); end
        else seq.push_back(T_MEMWR);
      end
      2'b00: begin
        if (!f[5] && ism) begin
          for (int i = 0; i < MUL_N; i++) seq.push_back(T_MULEX);
          seq.push_back(T_ALUWB);
        end else begin
          seq.push_back(f[5] ? T_EXECI : T_EXECR);
          if (!is_skip(f)) seq.push_back(T_ALUWB);
        end
      end
      2'b10: seq.push_back(T_BRANCH);
      default: ;
    endcase
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH of the next instruction.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic ism, input int exp_len);
    int seq[$];
    int mk;
    logic [22:0] e;
    Op = op; Funct = f; Rd = rd; IsMul = ism;
    build_seq(op, f, ism, seq);
    n_checks++;
    if (exp_len >= 0 && seq.size() !== exp_len) begin
      n_fail++;
      $display("FAIL %s latency model got %0d exp %0d", name, seq.size(), exp_len);
    end
    mk = 0;
    foreach (seq[i]) begin
      if (seq[i] == T_MULEX) mk++;
      e = exp_vec(seq[i], op, f, rd, ism, mk == MUL_N);
      #1;
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d state %0d got %h exp %h", name, i, seq[i], got, e);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic check_fetch(input string name);
    #1;
    n_checks++;
    if (got !== exp_vec(T_FETCH, Op, Funct, Rd, IsMul, 0)) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", name, got,
               exp_vec(T_FETCH, Op, Funct, Rd, IsMul, 0));
    end
  endtask

  task automatic test_reset();
    reset = 1; Op = 2'b11; Funct = 6'h2A; Rd = 4'h3; IsMul = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_fetch("reset_held");
    reset = 0;
    @(posedge clk); @(negedge clk);
    #1;
    n_checks++;
    if (got !== exp_vec(T_DECODE, Op, Funct, Rd, IsMul, 0)) begin
      n_fail++;
      $display("FAIL reset_then_decode got %h exp %h", got,
               exp_vec(T_DECODE, Op, Funct, Rd, IsMul, 0));
    end
    @(posedge clk); @(negedge clk);
    check_fetch("undef_back_to_fetch");
  endtask

  task automatic test_dataproc();
    run_instr("adds_reg", 2'b00, 6'b001001, 4'd3, 0, 4);
    run_instr("sub_imm_pc", 2'b00, 6'b100100, 4'hF, 0, 4);
    run_instr("orr_reg", 2'b00, 6'b011000, 4'd7, 0, 4);
    run_instr("eors_reg", 2'b00, 6'b000011, 4'd1, 0, 4);
  endtask

  task automatic test_load_store();
    run_instr("ldr", 2'b01, 6'b011001, 4'd2, 0, 5);
    run_instr("ldr_pc", 2'b01, 6'b011001, 4'hF, 0, 5);
    run_instr("str", 2'b01, 6'b011000, 4'd2, 0, 4);
    run_instr("branch", 2'b10, 6'b100000, 4'd0, 0, 3);
  endtask

  task automatic test_mul();
    run_instr("mul", 2'b00, 6'b000000, 4'd4, 1, 3 + MUL_N);
    run_instr("muls", 2'b00, 6'b000001, 4'd5, 1, 3 + MUL_N);
  endtask

  task automatic test_mul_reset();
    Op = 2'b00; Funct = 6'b000001; Rd = 4'd6; IsMul = 1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #1;
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_reset_busy got %b exp 1", Busy);
    end
    reset = 1;
    @(posedge clk); @(negedge clk);
    reset = 0;
    check_fetch("mul_abort_fetch");
    run_instr("mul_after_abort", 2'b00, 6'b000001, 4'd6, 1, 3 + MUL_N);
  endtask

  task automatic test_undef();
    run_instr("undef", 2'b11, 6'b101010, 4'd9, 0, 2);
    run_instr("alu_other_0111", 2'b00, 6'b001111, 4'd8, 0, 4);
  endtask

  task automatic test_cmp();
`ifdef CMP_SKIP_WB_EN
    run_instr("cmp", 2'b00, 6'b010101, 4'd0, 0, 3);
    run_instr("tst_imm", 2'b00, 6'b110001, 4'hF, 0, 3);
`else
    run_instr("cmp", 2'b00, 6'b010101, 4'd0, 0, 4);
    run_instr("tst_imm", 2'b00, 6'b110001, 4'hF, 0, 4);
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 80; k++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr("random", op, f, rd, 1'($urandom), -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_dataproc();
    test_load_store();
    test_mul();
    test_mul_reset();
    test_undef();
    test_cmp();
    test_back_to_back();
    check_fetch("final_fetch");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Next-generation multicycle control unit for the ARM-subset core. Holds the main state machine, ALU decoder, PC-select logic and instruction decoder in one block.
- Extends the existing decoder with a parametrised multi-cycle multiply state, configurable ALUControl width, explicit undefined-opcode signalling and a deterministic default ALU encoding.
- Sits between the instruction register and the conditional/PC-write logic.

Parameters:
- ALUCTRL_W, 3: width of ALUControl; must be ≥3; bits above [2] are driven 0.
- MUL_CYCLES, 4: number of cycles spent in state MULEX; must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]
- Rd  input  4  Instr[15:12]
- IsMul  input  1  high when Instr[7:4]==1001 (multiply pattern)
- FlagW  output  2  flag write enables {NZ, CV}
- PCS  output  1  PC-source request
- NextPC  output  1  unconditional PC increment
- RegW  output  1  register-file write (pre-condition)
- MemW  output  1  memory write (pre-condition)
- IRWrite  output  1  instruction register load
- AdrSrc  output  1  memory address select
- ResultSrc  output  2  result mux select
- ALUSrcA  output  2  ALU A select
- ALUSrcB  output  2  ALU B select
- ImmSrc  output  2  immediate extend select
- RegSrc  output  2  register read-address selects
- ALUControl  output  ALUCTRL_W  ALU operation
- Undef  output  1  one-cycle pulse on undefined opcode
- Busy  output  1  high while in MULEX

Behaviour:
- Moore FSM: all outputs not listed for a state are 0. On the clk edge with reset=1, state←FETCH and mul counter←0. Reset mid-operation (including mid-MULEX) aborts immediately to FETCH.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Transitions:
  - Op=01 → MEMADR
  - Op=00, Funct[5]=0, IsMul=1 → MULEX
  - Op=00, Funct[5]=0 → EXECR
  - Op=00, Funct[5]=1 → EXECI
  - Op=10 → BRANCH
  - Op=11 → FETCH, with Undef=1 for this DECODE cycle only
- MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegW=1 → FETCH.
- MEMWR: AdrSrc=1, MemW=1 → FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1 → ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 → ALUWB.
- ALUWB: ResultSrc=00, RegW=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1 → FETCH.
- MULEX: ALUSrcA=00, ALUSrcB=00, ALUOp=1, Busy=1.
  - Counter increments each cycle.
  - When counter==MUL_CYCLES-1: counter←0, next state ALUWB.
  - MUL_CYCLES=1 means a single MULEX cycle.
- ALU decoder (combinational, from Funct[4:1] when ALUOp=1; in MULEX, IsMul overrides):
  - 0100→0 (ADD), 0010→1 (SUB), 0000→2 (AND), 1100→3 (ORR), 0001→4 (EOR), MUL→5
  - Any other code → 0; never X
  - ALUOp=0 → ALUControl=0
- FlagW:
  - ALUOp=0 → FlagW=00.
  - Otherwise FlagW[1]=Funct[0], and FlagW[0]=Funct[0]&(ALUControl∈{0,1}).
  - In MULEX, FlagW is nonzero only on the final MULEX cycle.
- PCS = Branch | (RegW & Rd==4'hF).
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).
- Latency per instruction class:
  - Load: 5 cycles
  - Store, data-processing: 4 cycles
  - Branch: 3 cycles
  - Multiply: 3+MUL_CYCLES cycles
  - Undefined: 2 cycles

Optional Feature:
- CMP_SKIP_WB_EN.
- Defined: Funct[4:1]=1010 (CMP) decodes to SUB and 1000 (TST) decodes to AND. For these codes, EXECR/EXECI go directly to FETCH, so RegW is never asserted; flags still follow the FlagW rule.
- Undefined: these codes take the default ALUControl=0 and pass through ALUWB as normal.

Test Plan:
- Reset held 2 cycles, then released → FETCH outputs (IRWrite=1, NextPC=1, ALUSrcB=10); next cycle DECODE.
- ADDS register form (Op=00, Funct=001001, Rd=3) → FETCH,DECODE,EXECR,ALUWB. ALUControl=0 and FlagW=11 in EXECR; RegW=1 in ALUWB; PCS=0.
- LDR (Op=01, Funct=011001) → FETCH,DECODE,MEMADR,MEMRD,MEMWB. RegW=1 only in MEMWB; STR (Funct[0]=0) asserts MemW only in MEMWR.
- MUL with MUL_CYCLES=4, IsMul=1 → Busy=1 for exactly 4 cycles, ALUControl=5, then ALUWB; reset asserted on the 2nd MULEX cycle → FETCH next edge with counter=0.
- Op=11 → Undef=1 for one cycle in DECODE, then FETCH; ALU-op Funct[4:1]=0111 → ALUControl=0 with no X.
- With CMP_SKIP_WB_EN, CMP (Funct=010101) → EXECR→FETCH, FlagW=11, RegW never 1; without the macro → passes through ALUWB with RegW=1.
